// File: rtl/gnr_floyd_ctrl.sv
// Floyd cycle-detection sequencer for one dual-copy Boolean gene-regulatory network.
// Finds the transient length (mu), the attractor period (lambda) and one attractor state.
module gnr_floyd_ctrl #(
    parameter int unsigned          NUM_NODES = 8,
    parameter int unsigned          CNT_W     = 16,
    parameter logic [CNT_W-1:0]     MAX_STEPS = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_NODES-1:0] seed,
    input  logic [NUM_NODES-1:0] s0_vec,
    input  logic [NUM_NODES-1:0] s1_vec,
    output logic                 reset_nos,
    output logic                 start_s0,
    output logic                 start_s1,
    output logic [NUM_NODES-1:0] init_state,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_W-1:0]     period,
    output logic [CNT_W-1:0]     transient,
    output logic [NUM_NODES-1:0] attractor_state
);

    typedef enum logic [3:0] {
        IDLE, LOAD1, DA, DB, DCMP, PSTEP, PCMP, LOAD2, ADV, MCMP, MA, MB, DONE
    } state_t;

    localparam logic [CNT_W-1:0] DET_LIMIT = MAX_STEPS - CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] lambda_cnt;
    logic [CNT_W-1:0] mu_cnt;
    logic [CNT_W-1:0] adv_cnt;
    logic             vec_eq;

    assign vec_eq = (s0_vec == s1_vec);

    // NOTE: every strobe is assigned on the edge that enters its state, so the
    // strobe is high exactly while the FSM sits in that state and the node
    // array has updated by the time the following CMP state samples s0/s1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            reset_nos       <= 1'b0;
            start_s0        <= 1'b0;
            start_s1        <= 1'b0;
            init_state      <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            timeout         <= 1'b0;
            period          <= '0;
            transient       <= '0;
            attractor_state <= '0;
            step_cnt        <= '0;
            lambda_cnt      <= '0;
            mu_cnt          <= '0;
            adv_cnt         <= '0;
        end else begin
            reset_nos <= 1'b0;
            start_s0  <= 1'b0;
            start_s1  <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        init_state <= seed;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                        period     <= '0;
                        transient  <= '0;
                        step_cnt   <= '0;
                        lambda_cnt <= '0;
                        mu_cnt     <= '0;
                        adv_cnt    <= '0;
                        reset_nos  <= 1'b1;
                        state      <= LOAD1;
                    end
                end

                LOAD1, DA: begin
                    start_s0 <= 1'b1;
                    start_s1 <= 1'b1;
                    state    <= (state == LOAD1) ? DA : DB;
                end

                DB: state <= DCMP;

                // Detection: tortoise s0 moves one step per round, hare s1 two.
                DCMP: begin
                    if (vec_eq) begin
                        attractor_state <= s0_vec;
                        start_s1        <= 1'b1;
                        state           <= PSTEP;
                    end else if (step_cnt == DET_LIMIT) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                        period    <= lambda_cnt;
                        transient <= mu_cnt;
                        state     <= DONE;
                    end else begin
                        step_cnt <= step_cnt + CNT_W'(1);
                        start_s0 <= 1'b1;
                        start_s1 <= 1'b1;
                        state    <= DA;
                    end
                end

                PSTEP: begin
                    lambda_cnt <= lambda_cnt + CNT_W'(1);
                    state      <= PCMP;
                end

                // Period: s0 stays on the cycle while s1 walks around it once.
                PCMP: begin
                    if (vec_eq) begin
                        period    <= lambda_cnt;
                        reset_nos <= 1'b1;
                        state     <= LOAD2;
                    end else if (lambda_cnt == MAX_STEPS) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                        period    <= lambda_cnt;
                        transient <= mu_cnt;
                        state     <= DONE;
                    end else begin
                        start_s1 <= 1'b1;
                        state    <= PSTEP;
                    end
                end

                LOAD2: begin
                    adv_cnt  <= lambda_cnt;
                    start_s1 <= 1'b1;
                    state    <= ADV;
                end

                // s1 is pushed lambda steps ahead of the reloaded s0.
                ADV: begin
                    adv_cnt <= adv_cnt - CNT_W'(1);
                    if (adv_cnt == CNT_W'(1)) begin
                        state <= MCMP;
                    end else begin
                        start_s1 <= 1'b1;
                    end
                end

                MCMP: begin
                    if (vec_eq) begin
                        transient <= mu_cnt;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (mu_cnt == MAX_STEPS) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                        period    <= lambda_cnt;
                        transient <= mu_cnt;
                        state     <= DONE;
                    end else begin
                        start_s0 <= 1'b1;
                        start_s1 <= 1'b1;
                        state    <= MA;
                    end
                end

                MA: begin
                    start_s0 <= 1'b1;
                    state    <= MB;
                end

                MB: begin
                    mu_cnt <= mu_cnt + CNT_W'(1);
                    state  <= MCMP;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gnr_floyd_ctrl.sv
// Self-checking bench for gnr_floyd_ctrl: behavioural node arrays driven by a
// lookup-table network function, and a sequence-based mu/lambda reference.
module tb_gnr_floyd_ctrl;

    localparam int W  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  seed;
    logic [W-1:0]  s0_vec, s1_vec;
    logic          reset_nos, start_s0, start_s1;
    logic [W-1:0]  init_state;
    logic          busy, done, timeout;
    logic [CW-1:0] period, transient;
    logic [W-1:0]  attractor_state;

    // Second instance: 2-node network with a tiny step limit.
    logic          t_start;
    logic [1:0]    t_s0_vec, t_s1_vec;
    logic          t_reset_nos, t_start_s0, t_start_s1;
    logic [1:0]    t_init_state;
    logic          t_busy, t_done, t_timeout;
    logic [CW-1:0] t_period, t_transient;
    logic [1:0]    t_attractor_state;

    always #5 clk = ~clk;

    gnr_floyd_ctrl #(.NUM_NODES(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .s0_vec(s0_vec), .s1_vec(s1_vec),
        .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1),
        .init_state(init_state), .busy(busy), .done(done), .timeout(timeout),
        .period(period), .transient(transient), .attractor_state(attractor_state)
    );

    gnr_floyd_ctrl #(.NUM_NODES(2), .CNT_W(CW), .MAX_STEPS(16'd2)) dut_t (
        .clk(clk), .rst(rst), .start(t_start), .seed(2'b00),
        .s0_vec(t_s0_vec), .s1_vec(t_s1_vec),
        .reset_nos(t_reset_nos), .start_s0(t_start_s0), .start_s1(t_start_s1),
        .init_state(t_init_state), .busy(t_busy), .done(t_done), .timeout(t_timeout),
        .period(t_period), .transient(t_transient), .attractor_state(t_attractor_state)
    );

    // Network function as a lookup table; s0 is the pass copy, s1 the plain copy.
    logic [W-1:0] fmap [16];
    logic         used, t_used;

    always @(posedge clk) begin
        if (rst) begin
            s0_vec <= '0; s1_vec <= '0; used <= 1'b0;
        end else if (reset_nos) begin
            s0_vec <= init_state; s1_vec <= init_state; used <= 1'b0;
        end else begin
            if (start_s0 && !used) s0_vec <= fmap[s0_vec];
            used <= start_s0 && !used;
            if (start_s1) s1_vec <= fmap[s1_vec];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            t_s0_vec <= '0; t_s1_vec <= '0; t_used <= 1'b0;
        end else if (t_reset_nos) begin
            t_s0_vec <= t_init_state; t_s1_vec <= t_init_state; t_used <= 1'b0;
        end else begin
            if (t_start_s0 && !t_used) t_s0_vec <= t_s0_vec + 2'd1;
            t_used <= t_start_s0 && !t_used;
            if (t_start_s1) t_s1_vec <= t_s1_vec + 2'd1;
        end
    end

    // Strobe activity counters; runs are measured as differences of snapshots.
    int n_rst = 0, n_both = 0, n_s1 = 0, n_s0 = 0, n_viol = 0, t_both = 0;
    int b_rst, b_both, b_s1, b_s0, b_viol;

    always @(posedge clk) begin
        if (!rst) begin
            if (reset_nos) n_rst++;
            if (start_s0 && start_s1) n_both++;
            if (start_s1 && !start_s0) n_s1++;
            if (start_s0 && !start_s1) n_s0++;
            if (reset_nos && (start_s0 || start_s1)) n_viol++;
            if (t_start_s0 && t_start_s1) t_both++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Iterate the map from the seed; mu/lambda from the first repeated state,
    // meet round from the first i>=1 with x(i) == x(2i).
    task automatic ref_model(input logic [W-1:0] s, output int lam, output int mu,
                             output int meet, output logic [W-1:0] att);
        logic [W-1:0] seq [40];
        seq[0] = s;
        for (int k = 1; k < 40; k++) seq[k] = fmap[seq[k-1]];
        lam = 0; mu = 0; meet = 0;
        for (int j = 1; j < 40; j++)
            for (int k = 0; k < j; k++)
                if (lam == 0 && seq[k] == seq[j]) begin
                    mu  = k;
                    lam = j - k;
                end
        for (int i = 1; i < 20; i++)
            if (meet == 0 && seq[i] == seq[2*i]) meet = i;
        att = seq[meet];
    endtask

    task automatic launch(input logic [W-1:0] s);
        @(negedge clk);
        seed = s;
        start = 1'b1;
        b_rst = n_rst; b_both = n_both; b_s1 = n_s1; b_s0 = n_s0; b_viol = n_viol;
        @(negedge clk);
        start = 1'b0;
        seed = W'($urandom);
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        check({tag, "_done_seen"}, ok, 1);
    endtask

    task automatic finish_check(input string tag, input int lam, input int mu,
                                input int meet, input logic [W-1:0] att);
        wait_done(tag);
        check({tag, "_timeout"},   timeout, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_period"},    period, lam);
        check({tag, "_transient"}, transient, mu);
        check({tag, "_attractor"}, attractor_state, att);
        check({tag, "_n_reload"},  n_rst - b_rst, 2);
        check({tag, "_n_both"},    n_both - b_both, 2 * meet + mu);
        check({tag, "_n_s1only"},  n_s1 - b_s1, 2 * lam);
        check({tag, "_n_s0only"},  n_s0 - b_s0, mu);
        check({tag, "_overlap"},   n_viol - b_viol, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_done"},       done, 0);
        check({tag, "_timeout"},    timeout, 0);
        check({tag, "_period"},     period, 0);
        check({tag, "_transient"},  transient, 0);
        check({tag, "_attractor"},  attractor_state, 0);
        check({tag, "_init_state"}, init_state, 0);
        check({tag, "_strobes"},    {reset_nos, start_s0, start_s1}, 0);
    endtask

    initial begin
        int lam, mu, meet;
        logic [W-1:0] att, s;
        bit ok;

        rst = 1'b1; start = 1'b0; seed = '0; t_start = 1'b0;
        for (int i = 0; i < 16; i++) fmap[i] = W'(i);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // f(x)=x: fixed point, meet on the first round.
        launch(4'b0010);
        check("start_busy", busy, 1);
        finish_check("ident", 1, 0, 1, 4'b0010);

        // f(x)=0 from 3: one transient step into the fixed point 0.
        for (int i = 0; i < 16; i++) fmap[i] = '0;
        launch(4'b0011);
        finish_check("const", 1, 1, 1, 4'b0000);

        // f(x)=x+1 mod 4 from 0: pure 4-cycle, meet at round 4.
        for (int i = 0; i < 16; i++) fmap[i] = W'((i + 1) % 4);
        launch(4'b0000);
        finish_check("inc4", 4, 0, 4, 4'b0000);

        // Same cycle with a two-step limit: detection aborts after two rounds.
        @(negedge clk);
        t_start = 1'b1;
        b_both  = t_both;
        @(negedge clk);
        t_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (t_done) ok = 1'b1;
        end
        check("tmo_done_seen", ok, 1);
        check("tmo_timeout",   t_timeout, 1);
        check("tmo_busy",      t_busy, 0);
        check("tmo_period",    t_period, 0);
        check("tmo_transient", t_transient, 0);
        check("tmo_rounds",    t_both - b_both, 4);

        // Reset while s1 is being advanced ahead of s0.
        launch(4'b0001);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (n_rst - b_rst == 2 && start_s1 && !start_s0) ok = 1'b1;
        end
        check("adv_reached", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_rst");
        rst = 1'b0;
        launch(4'b0010);
        finish_check("after_rst", 4, 0, 4, 4'b0010);

        // Start during DB is ignored; start in DONE restarts with a reload.
        launch(4'b0011);
        @(negedge clk);
        @(negedge clk);
        check("db_strobes", {start_s0, start_s1}, 2'b11);
        start = 1'b1;
        seed = 4'b0000;
        @(negedge clk);
        start = 1'b0;
        check("db_busy_kept", busy, 1);
        check("db_no_reload", reset_nos, 0);
        finish_check("ign_start", 4, 0, 4, 4'b0011);
        launch(4'b0010);
        check("restart_reload", reset_nos, 1);
        check("restart_busy",   busy, 1);
        check("restart_done",   done, 0);
        finish_check("restart", 4, 0, 4, 4'b0010);

        // Random networks and seeds against the sequence reference.
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 16; i++) fmap[i] = W'($urandom);
            s = W'($urandom);
            ref_model(s, lam, mu, meet, att);
            launch(s);
            finish_check($sformatf("rand%0d", r), lam, mu, meet, att);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
